// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes, field positions.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status field positions
    localparam int STATUS_BEV_BIT = 22;
    localparam int STATUS_IM_LSB  = 8;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IE_BIT  = 0;

    // Cause field positions
    localparam int CAUSE_BD_BIT  = 31;
    localparam int CAUSE_TI_BIT  = 30;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_EXC_LSB = 2;

    // Architectural Status state (BEV is read-only after reset)
    typedef struct packed {
        logic       bev;
        logic [7:0] im;
        logic       exl;
        logic       ie;
    } status_t;

    // Only address errors capture the faulting address into BadVAddr
    function automatic logic is_addr_err(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

    // Place Status fields into their read-back word; unlisted bits stay 0
    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] w;
        w = '0;
        w[STATUS_BEV_BIT]          = s.bev;
        w[STATUS_IM_LSB +: 8]      = s.im;
        w[STATUS_EXL_BIT]          = s.exl;
        w[STATUS_IE_BIT]           = s.ie;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 timer: clock divider, Count, Compare and the timer-interrupt (TI) flag.
// Latency: register writes visible the cycle after the write; TI sets on the match edge.
// Backpressure: none; writes are single-cycle strobes and always accepted.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int                DIV_W   = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic             tick;
    logic [31:0]      count_inc;

    // Next-state: a Count write reloads and restarts the divider; a Compare write clears TI last so it wins
    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        tick      = (div_q == DIV_MAX);
        count_inc = count_q + 32'd1;

        if (count_we) begin
            count_d = wdata;
            div_d   = '0;
        end else if (tick) begin
            div_d   = '0;
            count_d = count_inc;
            if (count_inc == compare_q) begin
                ti_d = 1'b1;
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        if (compare_we) begin
            compare_d = wdata;
            ti_d      = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_ext.sv
// CP0 subset: Status/Cause/EPC/BadVAddr plus timer, exception entry/ERET and interrupt request.
// Latency: MTC0 and exception updates visible next cycle; rdata/int_req/epc_out are combinational from state.
// Backpressure: none; an exception in the same cycle silently drops a concurrent MTC0.
module cp0_ext
    import cp0_pkg::*;
#(
    parameter int HW_INTS   = 6,
    parameter int COUNT_DIV = 2,
    parameter int BEV_RESET = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mtc0_we,
    input  logic [4:0]         mtc0_addr,
    input  logic [31:0]        mtc0_wdata,
    input  logic [4:0]         raddr,
    output logic [31:0]        rdata,
    input  logic               ex_valid,
    input  logic [4:0]         ex_excode,
    input  logic               ex_bd,
    input  logic [31:0]        ex_pc,
    input  logic [31:0]        ex_badvaddr,
    input  logic               eret,
    input  logic [HW_INTS-1:0] hw_int,
    output logic               int_req,
    output logic [31:0]        epc_out
);

    status_t     status_q, status_d;
    logic        bd_q, bd_d;
    logic [4:0]  excode_q, excode_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  ip_hw_q, ip_hw_d;
    logic        hw5_q, hw5_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic        wr_en;
    logic        count_we;
    logic        compare_we;
    logic [5:0]  hw_pad;
    logic [7:0]  ip;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [31:0] cause_word;

    // Absent interrupt lines read as 0 in the IP field
    assign hw_pad = 6'(hw_int);

    // An exception in the same cycle swallows the MTC0 completely
    assign wr_en      = mtc0_we && !ex_valid;
    assign count_we   = wr_en && (mtc0_addr == REG_COUNT);
    assign compare_we = wr_en && (mtc0_addr == REG_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (count_we),
        .compare_we (compare_we),
        .wdata      (mtc0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Next-state: MTC0 first, then exception entry or ERET; exception beats ERET
    always_comb begin
        status_d   = status_q;
        bd_d       = bd_q;
        excode_d   = excode_q;
        ip_sw_d    = ip_sw_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ip_hw_d    = hw_pad[4:0];
        hw5_d      = hw_pad[5];

        if (wr_en) begin
            case (mtc0_addr)
                REG_STATUS: begin
                    status_d.im  = mtc0_wdata[STATUS_IM_LSB +: 8];
                    status_d.exl = mtc0_wdata[STATUS_EXL_BIT];
                    status_d.ie  = mtc0_wdata[STATUS_IE_BIT];
                end
                REG_CAUSE: ip_sw_d = mtc0_wdata[CAUSE_IP_LSB +: 2];
                REG_EPC:   epc_d   = mtc0_wdata;
                default:   ;
            endcase
        end

        if (ex_valid) begin
            // A nested exception keeps the original return address
            if (!status_q.exl) begin
                epc_d = ex_bd ? (ex_pc - 32'd4) : ex_pc;
                bd_d  = ex_bd;
            end
            excode_d     = ex_excode;
            status_d.exl = 1'b1;
            if (is_addr_err(ex_excode)) begin
                badvaddr_d = ex_badvaddr;
            end
        end else if (eret) begin
            status_d.exl = 1'b0;
        end
    end

    // Architectural register state; BEV only changes on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            status_q     <= '0;
            status_q.bev <= 1'(BEV_RESET);
            bd_q         <= 1'b0;
            excode_q     <= '0;
            ip_sw_q      <= '0;
            ip_hw_q      <= '0;
            hw5_q        <= 1'b0;
            epc_q        <= '0;
            badvaddr_q   <= '0;
        end else begin
            status_q     <= status_d;
            bd_q         <= bd_d;
            excode_q     <= excode_d;
            ip_sw_q      <= ip_sw_d;
            ip_hw_q      <= ip_hw_d;
            hw5_q        <= hw5_d;
            epc_q        <= epc_d;
            badvaddr_q   <= badvaddr_d;
        end
    end

    // Interrupt pending vector and Cause read word
    always_comb begin
        ip         = {ti | hw5_q, ip_hw_q, ip_sw_q};
        cause_word = '0;
        cause_word[CAUSE_BD_BIT]         = bd_q;
        cause_word[CAUSE_TI_BIT]         = ti;
        cause_word[CAUSE_IP_LSB +: 8]    = ip;
        cause_word[CAUSE_EXC_LSB +: 5]   = excode_q;
    end

    // MFC0 read mux; unimplemented registers read 0
    always_comb begin
        rdata = '0;
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = pack_status(status_q);
            REG_CAUSE:    rdata = cause_word;
            REG_EPC:      rdata = epc_q;
            default:      rdata = '0;
        endcase
    end

    assign int_req = status_q.ie && !status_q.exl && (|(ip & status_q.im));
    assign epc_out = epc_q;

endmodule

// File: tb/tb_cp0_ext.sv
module tb_cp0_ext;
    import cp0_pkg::*;

    localparam int HW_INTS = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic               mtc0_we;
    logic [4:0]         mtc0_addr;
    logic [31:0]        mtc0_wdata;
    logic [4:0]         raddr;
    logic [31:0]        rdata;
    logic               ex_valid;
    logic [4:0]         ex_excode;
    logic               ex_bd;
    logic [31:0]        ex_pc;
    logic [31:0]        ex_badvaddr;
    logic               eret;
    logic [HW_INTS-1:0] hw_int;
    logic               int_req;
    logic [31:0]        epc_out;

    int checks = 0;
    int errors = 0;

    cp0_ext #(
        .HW_INTS   (HW_INTS),
        .COUNT_DIV (2),
        .BEV_RESET (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mtc0_we     (mtc0_we),
        .mtc0_addr   (mtc0_addr),
        .mtc0_wdata  (mtc0_wdata),
        .raddr       (raddr),
        .rdata       (rdata),
        .ex_valid    (ex_valid),
        .ex_excode   (ex_excode),
        .ex_bd       (ex_bd),
        .ex_pc       (ex_pc),
        .ex_badvaddr (ex_badvaddr),
        .eret        (eret),
        .hw_int      (hw_int),
        .int_req     (int_req),
        .epc_out     (epc_out)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp_rdata;
        logic        exp_int;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we    = 1'b1;
        mtc0_addr  = a;
        mtc0_wdata = d;
        tick();
        mtc0_we    = 1'b0;
    endtask

    task automatic exc(input logic bd, input logic [31:0] pc, input logic [4:0] code,
                       input logic [31:0] bva, input logic with_eret);
        ex_valid    = 1'b1;
        ex_bd       = bd;
        ex_pc       = pc;
        ex_excode   = code;
        ex_badvaddr = bva;
        eret        = with_eret;
        tick();
        ex_valid    = 1'b0;
        eret        = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_int"}, {31'b0, int_req}, 32'h0);
        chk({tag, "_epc_out"}, epc_out, 32'h0);
        rd_chk({tag, "_status"}, REG_STATUS, 32'h0040_0000);
        rd_chk({tag, "_cause"}, REG_CAUSE, 32'h0);
        rd_chk({tag, "_epc"}, REG_EPC, 32'h0);
        rd_chk({tag, "_badvaddr"}, REG_BADVADDR, 32'h0);
        rd_chk({tag, "_count"}, REG_COUNT, 32'h0);
        rd_chk({tag, "_compare"}, REG_COMPARE, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0]  = '{REG_STATUS,   32'hFFFF_FFFF, REG_STATUS,   32'h0040_FF03, 1'b0};
        vecs[1]  = '{REG_STATUS,   32'h0000_0000, REG_STATUS,   32'h0040_0000, 1'b0};
        vecs[2]  = '{REG_CAUSE,    32'hFFFF_FFFF, REG_CAUSE,    32'h0000_0300, 1'b0};
        vecs[3]  = '{REG_STATUS,   32'h0000_0301, REG_STATUS,   32'h0040_0301, 1'b1};
        vecs[4]  = '{REG_STATUS,   32'h0000_0303, REG_STATUS,   32'h0040_0303, 1'b0};
        vecs[5]  = '{REG_STATUS,   32'h0000_0101, REG_STATUS,   32'h0040_0101, 1'b1};
        vecs[6]  = '{REG_CAUSE,    32'h0000_0000, REG_CAUSE,    32'h0000_0000, 1'b0};
        vecs[7]  = '{REG_STATUS,   32'h0000_0000, REG_STATUS,   32'h0040_0000, 1'b0};
        vecs[8]  = '{REG_EPC,      32'h1234_5678, REG_EPC,      32'h1234_5678, 1'b0};
        vecs[9]  = '{REG_BADVADDR, 32'h0000_DEAD, REG_BADVADDR, 32'h0000_0000, 1'b0};
        vecs[10] = '{5'd3,         32'hFFFF_FFFF, 5'd3,         32'h0000_0000, 1'b0};
        vecs[11] = '{REG_COMPARE,  32'hCAFE_BABE, REG_COMPARE,  32'hCAFE_BABE, 1'b0};
        vecs[12] = '{5'd16,        32'hFFFF_FFFF, REG_STATUS,   32'h0040_0000, 1'b0};

        // Reset held while every other event is active
        reset       = 1'b1;
        mtc0_we     = 1'b1;
        mtc0_addr   = REG_STATUS;
        mtc0_wdata  = 32'hFFFF_FFFF;
        raddr       = REG_STATUS;
        ex_valid    = 1'b1;
        ex_excode   = EXC_ADEL;
        ex_bd       = 1'b1;
        ex_pc       = 32'h0000_0444;
        ex_badvaddr = 32'h0000_0055;
        eret        = 1'b1;
        hw_int      = '0;
        tick();
        tick();
        tick();
        reset    = 1'b0;
        mtc0_we  = 1'b0;
        ex_valid = 1'b0;
        eret     = 1'b0;
        chk_reset_state("rst1");

        // Table of MTC0 writes with read-back and interrupt expectation
        for (int i = 0; i < NV; i++) begin
            mtc0(vecs[i].addr, vecs[i].wdata);
            rd_chk($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_int", i), {31'b0, int_req}, {31'b0, vecs[i].exp_int});
        end
        chk("epc_out_sw", epc_out, 32'h1234_5678);

        // Read in the write cycle sees the old value
        mtc0_we    = 1'b1;
        mtc0_addr  = REG_EPC;
        mtc0_wdata = 32'hAAAA_0000;
        rd_chk("rdw_old", REG_EPC, 32'h1234_5678);
        tick();
        mtc0_we = 1'b0;
        rd_chk("rdw_new", REG_EPC, 32'hAAAA_0000);

        // Timer match: Compare=5, Count=0, divide by 2 -> TI after 10 cycles
        mtc0(REG_COMPARE, 32'd5);
        mtc0(REG_COUNT, 32'd0);
        raddr = REG_CAUSE;
        #1;
        n = 0;
        while (rdata[CAUSE_TI_BIT] == 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk("ti_cycles", n, 32'd10);
        rd_chk("ti_cause", REG_CAUSE, 32'h4000_8000);
        rd_chk("ti_count", REG_COUNT, 32'd5);

        // Timer interrupt raises int_req; Compare write clears it
        mtc0(REG_STATUS, 32'h0000_8001);
        chk("ti_int_on", {31'b0, int_req}, 32'h1);
        mtc0(REG_COMPARE, 32'd100);
        rd_chk("ti_cleared_cause", REG_CAUSE, 32'h0);
        chk("ti_int_off", {31'b0, int_req}, 32'h0);

        // Compare write in the same cycle as a matching increment: clear wins
        mtc0(REG_COMPARE, 32'd10);
        mtc0(REG_COUNT, 32'd9);
        tick();
        mtc0(REG_COMPARE, 32'd10);
        rd_chk("cw_count", REG_COUNT, 32'd10);
        rd_chk("cw_cause", REG_CAUSE, 32'h0);

        // Delay-slot exception with a concurrent MTC0 that must be dropped
        mtc0_we    = 1'b1;
        mtc0_addr  = REG_EPC;
        mtc0_wdata = 32'h0000_5555;
        exc(1'b1, 32'hBFC0_0104, EXC_ADEL, 32'h0000_0013, 1'b0);
        chk("ex1_epc_out", epc_out, 32'hBFC0_0100);
        chk("ex1_int", {31'b0, int_req}, 32'h0);
        rd_chk("ex1_cause", REG_CAUSE, 32'h8000_0010);
        rd_chk("ex1_status", REG_STATUS, 32'h0040_8003);
        rd_chk("ex1_badvaddr", REG_BADVADDR, 32'h0000_0013);
        rd_chk("ex1_epc", REG_EPC, 32'hBFC0_0100);

        // Nested exception keeps EPC/BD, updates ExcCode, not an address error
        exc(1'b0, 32'h0000_0200, EXC_SYS, 32'h0000_0099, 1'b0);
        rd_chk("ex2_epc", REG_EPC, 32'hBFC0_0100);
        rd_chk("ex2_cause", REG_CAUSE, 32'h8000_0020);
        rd_chk("ex2_badvaddr", REG_BADVADDR, 32'h0000_0013);

        // Exception together with ERET: EXL stays set
        exc(1'b0, 32'h0000_0300, EXC_ADES, 32'h0000_0077, 1'b1);
        rd_chk("ex3_status", REG_STATUS, 32'h0040_8003);
        rd_chk("ex3_cause", REG_CAUSE, 32'h8000_0014);
        rd_chk("ex3_badvaddr", REG_BADVADDR, 32'h0000_0077);
        rd_chk("ex3_epc", REG_EPC, 32'hBFC0_0100);

        // ERET alone clears EXL
        eret = 1'b1;
        tick();
        eret = 1'b0;
        rd_chk("eret_status", REG_STATUS, 32'h0040_8001);

        // Fresh exception with EXL=0 captures EPC and clears BD
        exc(1'b0, 32'h0000_0300, EXC_INT, 32'h0000_0011, 1'b0);
        chk("ex4_epc_out", epc_out, 32'h0000_0300);
        rd_chk("ex4_cause", REG_CAUSE, 32'h0);
        rd_chk("ex4_badvaddr", REG_BADVADDR, 32'h0000_0077);
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // Count wraps from all-ones to zero
        mtc0(REG_COUNT, 32'hFFFF_FFFF);
        rd_chk("wrap_pre", REG_COUNT, 32'hFFFF_FFFF);
        tick();
        tick();
        rd_chk("wrap_post", REG_COUNT, 32'h0);

        // Hardware interrupt line 0 is registered before reaching int_req
        mtc0(REG_STATUS, 32'h0000_0401);
        hw_int = 6'b000001;
        #1;
        chk("hw0_int_pre", {31'b0, int_req}, 32'h0);
        tick();
        rd_chk("hw0_cause", REG_CAUSE, 32'h0000_0400);
        chk("hw0_int", {31'b0, int_req}, 32'h1);
        hw_int = '0;
        tick();
        chk("hw0_int_off", {31'b0, int_req}, 32'h0);

        // Line 5 shares IP[7] with TI; line 4 lands in IP[6]
        mtc0(REG_STATUS, 32'h0000_8001);
        hw_int = 6'b100000;
        tick();
        rd_chk("hw5_cause", REG_CAUSE, 32'h0000_8000);
        chk("hw5_int", {31'b0, int_req}, 32'h1);
        hw_int = 6'b010000;
        tick();
        rd_chk("hw4_cause", REG_CAUSE, 32'h0000_4000);
        chk("hw4_int", {31'b0, int_req}, 32'h0);
        hw_int = '0;
        tick();

        // Reset mid-run overrides concurrent exception, ERET and MTC0
        reset       = 1'b1;
        mtc0_we     = 1'b1;
        mtc0_addr   = REG_STATUS;
        mtc0_wdata  = 32'hFFFF_FFFF;
        ex_valid    = 1'b1;
        ex_bd       = 1'b1;
        ex_pc       = 32'h0000_0444;
        ex_excode   = EXC_ADEL;
        ex_badvaddr = 32'h0000_0055;
        eret        = 1'b1;
        tick();
        reset    = 1'b0;
        mtc0_we  = 1'b0;
        ex_valid = 1'b0;
        eret     = 1'b0;
        chk_reset_state("rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_ext.md
CP0_EXT -- requirements
Module: cp0_ext

Interface
REQ-001 Parameter HW_INTS, default 6, number of hardware interrupt lines (legal 1..6).
REQ-002 Parameter COUNT_DIV, default 2, clk cycles per Count increment (legal >=1).
REQ-003 Parameter BEV_RESET, default 1, Status.BEV value after reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mtc0_we  in  1  write strobe for MTC0.
REQ-007 mtc0_addr  in  5  CP0 register number for write.
REQ-008 mtc0_wdata  in  32  write data.
REQ-009 raddr  in  5  CP0 register number for read (MFC0).
REQ-010 rdata  out  32  read data, combinational from raddr and current register state.
REQ-011 ex_valid  in  1  exception commit this cycle.
REQ-012 ex_excode  in  5  exception code.
REQ-013 ex_bd  in  1  faulting instruction sits in a delay slot.
REQ-014 ex_pc  in  32  PC of faulting instruction.
REQ-015 ex_badvaddr  in  32  faulting address for address-error exceptions.
REQ-016 eret  in  1  ERET commit this cycle.
REQ-017 hw_int  in  HW_INTS  level-sensitive hardware interrupt lines.
REQ-018 int_req  out  1  enabled interrupt pending.
REQ-019 epc_out  out  32  current EPC, for the ERET redirect.

Function
REQ-020 Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); rdata returns 0 for any other raddr.
REQ-021 Status read format: bit22 BEV, bits15:8 IM, bit1 EXL, bit0 IE, all other bits 0.
REQ-022 Cause read format: bit31 BD, bit30 TI, bits15:8 IP, bits6:2 ExcCode, all other bits 0.
REQ-023 MTC0 writable fields: Status IM/EXL/IE; Cause IP[1:0] (software interrupts); Compare, Count and EPC in full; all other fields and registers ignore writes.
REQ-024 Reads in the cycle of a write return the old value; the new value is visible the following cycle.
REQ-025 Divider counts 0..COUNT_DIV-1; Count increments by 1 when the divider wraps, modulo 2^32 (0xFFFFFFFF -> 0).
REQ-026 An MTC0 write to Count loads the value and clears the divider; no increment occurs in that cycle.
REQ-027 TI sets in the cycle Count increments to a value equal to Compare; it stays set until an MTC0 write to Compare or reset.
REQ-028 An MTC0 write to Compare clears TI; if a match-increment coincides with that write, the clear wins.
REQ-029 Each cycle, Cause.IP[2+i] registers hw_int[i] for i < HW_INTS and min(i,5)<5; IP[7] = TI OR (HW_INTS==6 ? hw_int[5] : 0); unused IP bits read 0.
REQ-030 int_req = IE AND NOT EXL AND OR(IP AND IM), combinational from registered state.
REQ-031 On ex_valid with EXL=0: EPC <= ex_bd ? ex_pc-4 : ex_pc, and BD <= ex_bd.
REQ-032 On ex_valid with EXL=1: EPC and BD hold their values.
REQ-033 On every ex_valid: ExcCode <= ex_excode and EXL <= 1; IM and IE are unchanged.
REQ-034 BadVAddr <= ex_badvaddr only on ex_valid with ex_excode equal to AdEL (4) or AdES (5).
REQ-035 eret clears EXL.
REQ-036 ex_valid and eret in the same cycle: ex_valid wins.
REQ-037 ex_valid and mtc0_we in the same cycle: exception updates apply and the MTC0 write is dropped entirely.
REQ-038 epc_out always equals the EPC register.

Reset
REQ-039 While reset is high: Count, Compare, divider, EPC, BadVAddr, all Cause fields and Status IM/EXL/IE clear to 0, and BEV is set to BEV_RESET.
REQ-040 Reset overrides every concurrent ex_valid, eret, mtc0_we and timer event.
REQ-041 Outputs after reset: int_req=0, epc_out=0, rdata reflects the reset state.

Structure
REQ-042 Shared package cp0_pkg holds the register numbers, ExcCode constants (Int, AdEL, AdES, Sys, Bp, RI, Ov) and field bit positions.
REQ-043 The divider, Count, Compare and TI logic form one sub-module, cp0_timer.

Verification
REQ-044 Reset; MTC0 Compare=5, Count=0; COUNT_DIV=2 -> TI=1 after Count reaches 5 (about 10 cycles); Cause reads 0x40008000.
REQ-045 MTC0 Status=0x00008001, TI set -> int_req=1; then MTC0 Compare -> TI=0 and int_req=0 next cycle.
REQ-046 ex_valid, ex_bd=1, ex_pc=0xBFC00104, excode=4, badvaddr=0x13 -> EPC=0xBFC00100, BD=1, EXL=1, BadVAddr=0x13.
REQ-047 Second ex_valid while EXL=1 (pc=0x200) -> EPC unchanged, ExcCode updated; ex_valid together with eret -> EXL stays 1.
REQ-048 Count=0xFFFFFFFF -> wraps to 0; hw_int[0]=1 with IM[2]=1 and IE=1 -> IP[2]=1 next cycle, int_req=1.
